wb_burst_master: RTL and testbench

Synthesizable Wishbone B3 master engine that turns single commands on a valid/ready command port into classic or incrementing/wrapping burst cycles. Write beats come from a write-data stream; read beats go out on a read-data stream. It sits between a DMA or test sequencer and a Wishbone interconnect, and is the initiating end of the slave-side BFM used in the same benches.

---
 rtl/wb_burst_master.sv | 209 ++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one valid/ready command becomes a classic or
// linear/wrapping burst. Optional watchdog: define WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int lw      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [aw-1:0]     cmd_adr_i,
    input  logic [dw/8-1:0]   cmd_sel_i,
    input  logic [lw-1:0]     cmd_len_i,
    input  logic [1:0]        cmd_bte_i,
    input  logic [dw-1:0]     wdat_i,
    input  logic              wdat_valid_i,
    output logic              wdat_ready_o,
    output logic [dw-1:0]     rdat_o,
    output logic              rdat_valid_o,
    output logic              done_o,
    output logic              status_err_o,
    output logic [aw-1:0]     wb_adr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic [dw-1:0]     wb_rdt_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i
);

    localparam int BYTES = dw / 8;

    typedef enum logic [2:0] {S_IDLE, S_WFILL, S_BUS, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic              init_q;
    logic [lw-1:0]     cnt_q;
    logic [aw-1:0]     wb_adr_q, adr_d, adr_inc, wmask;
    logic [dw-1:0]     wb_dat_q, rdat_q;
    logic [dw/8-1:0]   wb_sel_q;
    logic              wb_we_q, wb_cyc_q, wb_stb_q;
    logic [2:0]        wb_cti_q;
    logic [1:0]        wb_bte_q;
    logic              rdat_valid_q, done_q, status_err_q;
    logic              tmo_hit, err_ev, ack_ev, last;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    // Counts strobed cycles without an ack; cleared whenever stb is low.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n || !wb_stb_q || wb_ack_i)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + TW'(1);
    end
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = (TIMEOUT < 0);
`endif

    assign err_ev = wb_stb_q && (wb_err_i || wb_rty_i || tmo_hit);
    assign ack_ev = wb_stb_q && wb_ack_i && !err_ev;
    assign last   = (cnt_q == '0);

    assign cmd_ready_o  = init_q && (state_q == S_IDLE || state_q == S_DONE);
    assign wdat_ready_o = (state_q == S_WFILL) || (state_q == S_DRAIN) ||
                          (state_q == S_BUS && wb_we_q && (!wb_stb_q || (ack_ev && !last)));

    // Wrap modes only advance the bits inside the N-beat block.
    always_comb begin
        adr_inc = wb_adr_q + aw'(BYTES);
        case (wb_bte_q)
            2'b01:   wmask = aw'(4 * BYTES - 1);
            2'b10:   wmask = aw'(8 * BYTES - 1);
            2'b11:   wmask = aw'(16 * BYTES - 1);
            default: wmask = '1;
        endcase
        adr_d = (wb_adr_q & ~wmask) | (adr_inc & wmask);
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q      <= S_IDLE;
            init_q       <= 1'b0;
            cnt_q        <= '0;
            wb_adr_q     <= '0;
            wb_dat_q     <= '0;
            wb_sel_q     <= '0;
            wb_we_q      <= 1'b0;
            wb_cyc_q     <= 1'b0;
            wb_stb_q     <= 1'b0;
            wb_cti_q     <= 3'b000;
            wb_bte_q     <= 2'b00;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            status_err_q <= 1'b0;
        end else begin
            init_q       <= 1'b1;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            status_err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        wb_we_q  <= cmd_we_i;
                        wb_adr_q <= cmd_adr_i;
                        wb_sel_q <= cmd_sel_i;
                        wb_bte_q <= cmd_bte_i;
                        cnt_q    <= cmd_len_i;
                        wb_cti_q <= (cmd_len_i == '0) ? 3'b000 : 3'b010;
                        if (cmd_we_i) begin
                            state_q <= S_WFILL;
                        end else begin
                            state_q  <= S_BUS;
                            wb_cyc_q <= 1'b1;
                            wb_stb_q <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WFILL: begin
                    if (wdat_valid_i) begin
                        wb_dat_q <= wdat_i;
                        wb_cyc_q <= 1'b1;
                        wb_stb_q <= 1'b1;
                        state_q  <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (err_ev) begin
                        wb_cyc_q <= 1'b0;
                        wb_stb_q <= 1'b0;
                        if (wb_we_q && !last) begin
                            // cnt_q now counts unconsumed write words minus one
                            cnt_q   <= cnt_q - lw'(1);
                            state_q <= S_DRAIN;
                        end else begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            status_err_q <= 1'b1;
                        end
                    end else if (ack_ev) begin
                        if (!wb_we_q) begin
                            rdat_q       <= wb_rdt_i;
                            rdat_valid_q <= 1'b1;
                        end
                        if (last) begin
                            wb_cyc_q <= 1'b0;
                            wb_stb_q <= 1'b0;
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                        end else begin
                            cnt_q    <= cnt_q - lw'(1);
                            wb_adr_q <= adr_d;
                            wb_cti_q <= (cnt_q == lw'(1)) ? 3'b111 : 3'b010;
                            if (wb_we_q) begin
                                if (wdat_valid_i)
                                    wb_dat_q <= wdat_i;
                                else
                                    wb_stb_q <= 1'b0;
                            end
                        end
                    end else if (!wb_stb_q && wdat_valid_i) begin
                        wb_dat_q <= wdat_i;
                        wb_stb_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (wdat_valid_i) begin
                        if (last) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            status_err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - lw'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_adr_o     = wb_adr_q;
    assign wb_dat_o     = wb_dat_q;
    assign wb_sel_o     = wb_sel_q;
    assign wb_we_o      = wb_we_q;
    assign wb_cyc_o     = wb_cyc_q;
    assign wb_stb_o     = wb_stb_q;
    assign wb_cti_o     = wb_cti_q;
    assign wb_bte_o     = wb_bte_q;
    assign rdat_o       = rdat_q;
    assign rdat_valid_o = rdat_valid_q;
    assign done_o       = done_q;
    assign status_err_o = status_err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master; the bench drives the
// Wishbone slave side cycle by cycle.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_bte;
    logic [31:0] wdat;
    logic        wdat_valid, wdat_ready;
    logic [31:0] rdat;
    logic        rdat_valid, done, status_err;
    logic [31:0] wb_adr, wb_dat, wb_rdt;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_burst_master #(.dw(32), .aw(32), .lw(4), .TIMEOUT(8)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte),
        .wdat_i(wdat), .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready),
        .rdat_o(rdat), .rdat_valid_o(rdat_valid), .done_o(done), .status_err_o(status_err),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_rdt_i(wb_rdt), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
    );

    // Outputs are sampled 1ns after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] len,
                         input logic [1:0] bte);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = 4'hF;
        cmd_len = len; cmd_bte = bte;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if ({wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb, wb_cti, wb_bte,
                       rdat, rdat_valid, done, status_err, wdat_ready, cmd_ready} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero adr=%h cyc=%b stb=%b rdy=%b exp all zero",
                               wb_adr, wb_cyc, wb_stb, cmd_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy_release got %b exp 0", cmd_ready); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy_after got %b exp 1", cmd_ready); end
    endtask

    task automatic test_single_read();
        issue(1'b0, 32'h100, 4'd0, 2'b00);
        checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b110) begin errors++; $display("FAIL rd1_cycstbwe got %b exp 110", {wb_cyc, wb_stb, wb_we}); end
        checks++; if (wb_adr !== 32'h100) begin errors++; $display("FAIL rd1_adr got %h exp 00000100", wb_adr); end
        checks++; if (wb_cti !== 3'b000) begin errors++; $display("FAIL rd1_cti got %b exp 000", wb_cti); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd1_busy_rdy got %b exp 0", cmd_ready); end
        tick();
        checks++; if (wb_stb !== 1'b1) begin errors++; $display("FAIL rd1_stb_wait got %b exp 1", wb_stb); end
        wb_ack = 1'b1; wb_rdt = 32'hDEADBEEF;
        tick();
        wb_ack = 1'b0;
        checks++; if ({rdat_valid, rdat} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL rd1_rdat got %b/%h exp 1/deadbeef", rdat_valid, rdat); end
        checks++; if ({done, status_err, wb_cyc, cmd_ready} !== 4'b1001) begin errors++; $display("FAIL rd1_done got %b exp 1001", {done, status_err, wb_cyc, cmd_ready}); end
        tick();
        checks++; if ({done, rdat_valid} !== 2'b00) begin errors++; $display("FAIL rd1_pulse got %b exp 00", {done, rdat_valid}); end
    endtask

    task automatic test_linear_write();
        issue(1'b1, 32'h40, 4'd3, 2'b00);
        checks++; if ({wdat_ready, wb_cyc} !== 2'b10) begin errors++; $display("FAIL wr_fill got %b exp 10", {wdat_ready, wb_cyc}); end
        tick();
        checks++; if ({wdat_ready, wb_stb} !== 2'b10) begin errors++; $display("FAIL wr_fill_gap got %b exp 10", {wdat_ready, wb_stb}); end
        wdat_valid = 1'b1; wdat = 32'd1;
        tick();
        wdat_valid = 1'b0;
        checks++; if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat, wb_cti} !== {3'b111, 32'h40, 32'd1, 3'b010}) begin
            errors++; $display("FAIL wr_beat0 got stb=%b adr=%h dat=%h cti=%b exp 1/40/1/010", wb_stb, wb_adr, wb_dat, wb_cti); end
        wb_ack = 1'b1;
        #1;
        checks++; if (wdat_ready !== 1'b1) begin errors++; $display("FAIL wr_rdy_on_ack got %b exp 1", wdat_ready); end
        tick();
        wb_ack = 1'b0;
        checks++; if ({wb_cyc, wb_stb, wdat_ready, wb_adr} !== {3'b101, 32'h44}) begin
            errors++; $display("FAIL wr_stall got cyc=%b stb=%b rdy=%b adr=%h exp 1/0/1/44", wb_cyc, wb_stb, wdat_ready, wb_adr); end
        tick();
        checks++; if ({wb_cyc, wb_stb} !== 2'b10) begin errors++; $display("FAIL wr_stall2 got %b exp 10", {wb_cyc, wb_stb}); end
        wdat_valid = 1'b1; wdat = 32'd2;
        tick();
        wdat_valid = 1'b0;
        checks++; if ({wb_stb, wb_adr, wb_dat, wb_cti} !== {1'b1, 32'h44, 32'd2, 3'b010}) begin
            errors++; $display("FAIL wr_beat1 got stb=%b adr=%h dat=%h cti=%b exp 1/44/2/010", wb_stb, wb_adr, wb_dat, wb_cti); end
        wb_ack = 1'b1; wdat_valid = 1'b1; wdat = 32'd3;
        tick();
        checks++; if ({wb_stb, wb_adr, wb_dat, wb_cti} !== {1'b1, 32'h48, 32'd3, 3'b010}) begin
            errors++; $display("FAIL wr_beat2 got stb=%b adr=%h dat=%h cti=%b exp 1/48/3/010", wb_stb, wb_adr, wb_dat, wb_cti); end
        wdat = 32'd4;
        tick();
        wdat_valid = 1'b0;
        checks++; if ({wb_stb, wb_adr, wb_dat, wb_cti} !== {1'b1, 32'h4C, 32'd4, 3'b111}) begin
            errors++; $display("FAIL wr_beat3 got stb=%b adr=%h dat=%h cti=%b exp 1/4c/4/111", wb_stb, wb_adr, wb_dat, wb_cti); end
        #1;
        checks++; if (wdat_ready !== 1'b0) begin errors++; $display("FAIL wr_last_rdy got %b exp 0", wdat_ready); end
        tick();
        wb_ack = 1'b0;
        checks++; if ({done, status_err, wb_cyc, wb_stb} !== 4'b1000) begin errors++; $display("FAIL wr_done got %b exp 1000", {done, status_err, wb_cyc, wb_stb}); end
        tick();
    endtask

    task automatic test_wrap_read();
        logic [31:0] exp_adr [4];
        exp_adr[0] = 32'h0C; exp_adr[1] = 32'h00; exp_adr[2] = 32'h04; exp_adr[3] = 32'h08;
        issue(1'b0, 32'h0C, 4'd3, 2'b01);
        wb_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({wb_stb, wb_adr, wb_bte, wb_cti} !== {1'b1, exp_adr[i], 2'b01, (i == 3) ? 3'b111 : 3'b010}) begin
                errors++; $display("FAIL wrap_beat%0d got stb=%b adr=%h bte=%b cti=%b exp adr %h", i, wb_stb, wb_adr, wb_bte, wb_cti, exp_adr[i]); end
            wb_rdt = 32'hA0 + 32'(i);
            tick();
            checks++; if ({rdat_valid, rdat} !== {1'b1, 32'hA0 + 32'(i)}) begin
                errors++; $display("FAIL wrap_rdat%0d got %b/%h exp 1/%h", i, rdat_valid, rdat, 32'hA0 + 32'(i)); end
        end
        wb_ack = 1'b0;
        checks++; if ({done, status_err, wb_cyc} !== 3'b100) begin errors++; $display("FAIL wrap_done got %b exp 100", {done, status_err, wb_cyc}); end
        tick();
    endtask

    task automatic test_err_write();
        issue(1'b1, 32'h200, 4'd3, 2'b00);
        wdat_valid = 1'b1; wdat = 32'h11;
        tick();
        wb_ack = 1'b1; wdat = 32'h22;
        tick();
        wb_ack = 1'b0; wdat_valid = 1'b0; wb_err = 1'b1;
        checks++; if ({wb_stb, wb_adr, wb_dat} !== {1'b1, 32'h204, 32'h22}) begin
            errors++; $display("FAIL werr_beat1 got stb=%b adr=%h dat=%h exp 1/204/22", wb_stb, wb_adr, wb_dat); end
        #1;
        checks++; if (wdat_ready !== 1'b0) begin errors++; $display("FAIL werr_rdy_on_err got %b exp 0", wdat_ready); end
        tick();
        wb_err = 1'b0;
        checks++; if ({wb_cyc, wb_stb, wdat_ready, done} !== 4'b0010) begin errors++; $display("FAIL werr_drain got %b exp 0010", {wb_cyc, wb_stb, wdat_ready, done}); end
        wdat_valid = 1'b1; wdat = 32'h33;
        tick();
        checks++; if ({wdat_ready, done} !== 2'b10) begin errors++; $display("FAIL werr_drain2 got %b exp 10", {wdat_ready, done}); end
        wdat = 32'h44;
        tick();
        wdat_valid = 1'b0;
        checks++; if ({done, status_err, cmd_ready, wdat_ready} !== 4'b1110) begin errors++; $display("FAIL werr_done got %b exp 1110", {done, status_err, cmd_ready, wdat_ready}); end
        // Back-to-back: next command is taken in the done cycle.
        issue(1'b0, 32'h300, 4'd0, 2'b00);
        checks++; if ({wb_cyc, wb_stb, wb_adr} !== {2'b11, 32'h300}) begin errors++; $display("FAIL b2b_start got cyc=%b adr=%h exp 1/300", wb_cyc, wb_adr); end
        wb_ack = 1'b1; wb_rdt = 32'h12345678;
        tick();
        wb_ack = 1'b0;
        checks++; if ({rdat_valid, rdat, done, status_err} !== {1'b1, 32'h12345678, 2'b10}) begin
            errors++; $display("FAIL b2b_done got v=%b d=%h done=%b err=%b exp 1/12345678/1/0", rdat_valid, rdat, done, status_err); end
        tick();
    endtask

    task automatic test_err_read();
        issue(1'b0, 32'h500, 4'd0, 2'b00);
        wb_ack = 1'b1; wb_err = 1'b1; wb_rdt = 32'hBAD0BAD0;
        tick();
        wb_ack = 1'b0; wb_err = 1'b0;
        checks++; if ({rdat_valid, done, status_err, wb_cyc} !== 4'b0110) begin errors++; $display("FAIL ackerr got %b exp 0110", {rdat_valid, done, status_err, wb_cyc}); end
        tick();
        issue(1'b0, 32'h600, 4'd1, 2'b00);
        wb_rty = 1'b1;
        tick();
        wb_rty = 1'b0;
        checks++; if ({rdat_valid, done, status_err, wb_cyc} !== 4'b0110) begin errors++; $display("FAIL rty got %b exp 0110", {rdat_valid, done, status_err, wb_cyc}); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h80, 4'd3, 2'b00);
        wb_ack = 1'b1; wb_rdt = 32'h55;
        tick(); tick();
        checks++; if ({wb_stb, wb_adr} !== {1'b1, 32'h88}) begin errors++; $display("FAIL rmid_pre got stb=%b adr=%h exp 1/88", wb_stb, wb_adr); end
        wb_ack = 1'b0; rst_n = 1'b0;
        tick();
        checks++; if ({wb_adr, wb_cyc, wb_stb, wb_cti, rdat_valid, done, status_err, cmd_ready} !== '0) begin
            errors++; $display("FAIL rmid_clear got adr=%h cyc=%b stb=%b done=%b rdy=%b exp all zero", wb_adr, wb_cyc, wb_stb, done, cmd_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if ({cmd_ready, done} !== 2'b10) begin errors++; $display("FAIL rmid_ready got %b exp 10", {cmd_ready, done}); end
        issue(1'b0, 32'h700, 4'd0, 2'b00);
        wb_ack = 1'b1; wb_rdt = 32'hCAFEF00D;
        tick();
        wb_ack = 1'b0;
        checks++; if ({rdat_valid, rdat, done, status_err} !== {1'b1, 32'hCAFEF00D, 2'b10}) begin
            errors++; $display("FAIL rmid_after got v=%b d=%h done=%b err=%b exp 1/cafef00d/1/0", rdat_valid, rdat, done, status_err); end
        tick();
    endtask

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int stb_cycles = 0;
        int waited = 0;
        issue(1'b0, 32'h800, 4'd0, 2'b00);
        while (!done && waited < 40) begin
            if (wb_stb) stb_cycles++;
            tick();
            waited++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done got %b exp 1 (waited %0d)", done, waited); end
        checks++; if (stb_cycles != 8) begin errors++; $display("FAIL tmo_stb_cycles got %0d exp 8", stb_cycles); end
        checks++; if ({status_err, wb_cyc} !== 2'b10) begin errors++; $display("FAIL tmo_err got %b exp 10", {status_err, wb_cyc}); end
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
        cmd_len = '0; cmd_bte = '0; wdat = '0; wdat_valid = 1'b0;
        wb_rdt = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
        test_reset();
        test_single_read();
        test_linear_write();
        test_wrap_read();
        test_err_write();
        test_err_read();
        test_reset_mid();
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
